// File: rtl/fast_msg_encoder.sv
// -----------------------------------------------------------------------------
// fast_msg_encoder
//
// Serialises one order message into a fixed 27-byte FAST-style frame and
// streams it out one byte per transfer over a valid/ready byte interface.
//
// Frame layout (byte index : content)
//   0      : 8'hFF presence map
//   1      : template_id with stop bit forced (bit 7 = 1)
//   2..9   : symbol, most significant byte first
//   10..13 : price, least significant byte first, stop bit forced on byte 13
//   14..17 : quantity, same encoding as price
//   18     : side
//   19..26 : timestamp, most significant byte first
//
// Ports
//   clk_fast        in   1   byte-stream clock, all logic on its rising edge
//   rstn            in   1   synchronous active-low reset
//   msg_valid       in   1   message fields valid
//   msg_ready       out  1   encoder accepts a message this cycle
//   template_id     in   8   template ID
//   symbol          in   64  8 ASCII bytes, [63:56] sent first
//   price           in   32  price in cents
//   quantity        in   32  order quantity
//   side            in   8   0 = buy, 1 = sell
//   timestamp       in   64  message timestamp
//   udp_data_out    out  8   encoded byte
//   udp_valid_out   out  1   udp_data_out valid
//   udp_ready_in    in   1   sink accepts the byte
//   udp_last_out    out  1   current byte is the final byte (index 26)
//   busy            out  1   a message is in flight
//   msg_sent_count  out  32  number of completed messages (wraps)
//
// Build option
//   FAST_ENC_GAP_EN : when defined, a one-cycle GAP state follows every
//                     frame and the same-cycle reload on the final byte is
//                     disabled, so frames are separated by at least two idle
//                     cycles. When undefined, a new message may be accepted
//                     on the final-byte transfer and its first byte follows
//                     on the very next cycle.
// -----------------------------------------------------------------------------
module fast_msg_encoder (
  input  logic        clk_fast,
  input  logic        rstn,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [7:0]  template_id,
  input  logic [63:0] symbol,
  input  logic [31:0] price,
  input  logic [31:0] quantity,
  input  logic [7:0]  side,
  input  logic [63:0] timestamp,
  output logic [7:0]  udp_data_out,
  output logic        udp_valid_out,
  input  logic        udp_ready_in,
  output logic        udp_last_out,
  output logic        busy,
  output logic [31:0] msg_sent_count
);

  localparam logic [4:0] LAST_IDX = 5'd26;

`ifdef FAST_ENC_GAP_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1
  } state_t;
`endif

  state_t      state_reg;
  state_t      state_next;
  logic [4:0]  idx_reg;
  logic [4:0]  idx_next;

  // Captured message fields; held for the whole frame so the inputs may
  // change freely once a message has been accepted.
  logic [7:0]  template_reg;
  logic [63:0] symbol_reg;
  logic [31:0] price_reg;
  logic [31:0] quantity_reg;
  logic [7:0]  side_reg;
  logic [63:0] timestamp_reg;

  logic [31:0] count_reg;

  logic        accept;
  logic        last_xfer;

  // ---------------------------------------------------------------------------
  // Frame byte table. Indexed directly by the 5-bit byte index; entries 27..31
  // are never selected while sending but keep the index width exact.
  // ---------------------------------------------------------------------------
  logic [7:0] msg_bytes [32];

  assign msg_bytes[0]  = 8'hFF;
  assign msg_bytes[1]  = template_reg | 8'h80;
  assign msg_bytes[18] = side_reg;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_be_fields
      // Symbol and timestamp go out big-endian.
      assign msg_bytes[2 + gi]  = symbol_reg[63 - 8*gi -: 8];
      assign msg_bytes[19 + gi] = timestamp_reg[63 - 8*gi -: 8];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_le_fields
      // Price and quantity go out little-endian; the top byte carries the
      // stop bit, which replaces bit 31 of the field.
      if (gi == 3) begin : g_stop
        assign msg_bytes[10 + gi] = price_reg[8*gi +: 8] | 8'h80;
        assign msg_bytes[14 + gi] = quantity_reg[8*gi +: 8] | 8'h80;
      end else begin : g_plain
        assign msg_bytes[10 + gi] = price_reg[8*gi +: 8];
        assign msg_bytes[14 + gi] = quantity_reg[8*gi +: 8];
      end
    end

    for (genvar gi = 27; gi < 32; gi++) begin : g_unused
      assign msg_bytes[gi] = 8'h00;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state and handshake logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    msg_ready     = 1'b0;
    udp_valid_out = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Held low while reset is asserted so nothing is taken in reset.
        msg_ready = rstn;
        if (msg_valid) begin
          state_next = ST_SEND;
          idx_next   = 5'd0;
        end
      end

      ST_SEND: begin
        udp_valid_out = 1'b1;
        if (udp_ready_in) begin
          if (idx_reg == LAST_IDX) begin
            idx_next = 5'd0;
`ifdef FAST_ENC_GAP_EN
            state_next = ST_GAP;
`else
            // Final byte is leaving this cycle: a waiting message can be
            // loaded now and start on the next cycle without a bubble.
            msg_ready  = rstn;
            state_next = msg_valid ? ST_SEND : ST_IDLE;
`endif
          end else begin
            idx_next = idx_reg + 5'd1;
          end
        end
      end

`ifdef FAST_ENC_GAP_EN
      ST_GAP: begin
        state_next = ST_IDLE;
        idx_next   = 5'd0;
      end
`endif

      default: begin
        state_next = ST_IDLE;
        idx_next   = 5'd0;
      end
    endcase
  end

  assign accept    = msg_valid && msg_ready;
  assign last_xfer = udp_valid_out && udp_ready_in && (idx_reg == LAST_IDX);

  // ---------------------------------------------------------------------------
  // State, index, field capture and message counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_fast) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= 5'd0;
      template_reg  <= 8'h00;
      symbol_reg    <= 64'h0;
      price_reg     <= 32'h0;
      quantity_reg  <= 32'h0;
      side_reg      <= 8'h00;
      timestamp_reg <= 64'h0;
      count_reg     <= 32'h0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;

      if (accept) begin
        template_reg  <= template_id;
        symbol_reg    <= symbol;
        price_reg     <= price;
        quantity_reg  <= quantity;
        side_reg      <= side;
        timestamp_reg <= timestamp;
      end

      // Natural 32-bit wrap from all-ones back to zero.
      if (last_xfer) begin
        count_reg <= count_reg + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Data, valid and last are functions of registered state only, so
  // they stay put while the sink holds udp_ready_in low.
  // ---------------------------------------------------------------------------
  assign udp_data_out   = (state_reg == ST_SEND) ? msg_bytes[idx_reg] : 8'h00;
  assign udp_last_out   = (state_reg == ST_SEND) && (idx_reg == LAST_IDX);
  assign busy           = (state_reg != ST_IDLE);
  assign msg_sent_count = count_reg;

endmodule
